// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer
// Runs one CPU memory transaction over the pin-multiplexed 8-bit external bus.
// Each transaction has three phases in order: address high byte, address low
// byte, then data.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   req_valid/req_ready         request handshake; ready only while IDLE
//   req_rw/req_addr/req_wdata   request fields, captured when accepted
//   rsp_valid/rsp_rdata/rsp_err one-cycle completion pulse, read data, timeout flag
//   rdy_in                      external ready; low stretches the data phase
//   pin_out                     address pins
//   pin_io_in/out/oe            bidirectional data pins (oe 1 = drive)
//
// Parameter WAIT_CYCLES (0..15): extra data-phase cycles beyond the first.
// Optional macro BUS_TIMEOUT_EN: abort the data phase after 255 consecutive
// rdy_in-low cycles, responding with rsp_err=1 (read data FF).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | bus released, ready for a request; may carry the rsp_valid pulse
// S_ADDR_HI| drive addr[15:8], rw flag on the data pins
// S_ADDR_LO| drive addr[7:0], rw flag on the data pins, load the wait counter
// S_DATA   | drive write data or release for a read; wait for rdy_in/counter
module ext_bus_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        rdy_in,
    output logic [7:0]  pin_out,
    input  logic [7:0]  pin_io_in,
    output logic [7:0]  pin_io_out,
    output logic [7:0]  pin_io_oe
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR_HI = 2'd1,
        S_ADDR_LO = 2'd2,
        S_DATA    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        timeout;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       rsp_err_q, rsp_err_d;

    // Counts consecutive stalled data cycles; the 255th stalled cycle aborts.
    always_comb begin
        tmo_cnt_d = 8'h00;
        if (state_q == S_DATA && !rdy_in) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    assign timeout   = (state_q == S_DATA) && !rdy_in && (tmo_cnt_q == 8'd254);
    assign rsp_err_d = timeout;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'h00;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    rw_d    = req_rw;
                    wdata_d = req_wdata;
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: state_d = S_ADDR_LO;
            S_ADDR_LO: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (timeout) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    if (rw_q) rsp_rdata_d = 8'hFF;
                end else if (rdy_in) begin
                    if (wait_cnt_q == 4'd0) begin
                        state_d     = S_IDLE;
                        rsp_valid_d = 1'b1;
                        if (rw_q) rsp_rdata_d = pin_io_in;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            wait_cnt_q  <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Pins are decoded straight from the state so the bus is released the
    // instant reset asserts.
    always_comb begin
        pin_out    = 8'h00;
        pin_io_out = 8'h00;
        pin_io_oe  = 8'h00;
        case (state_q)
            S_ADDR_HI: begin
                pin_out    = addr_q[15:8];
                pin_io_out = {7'b0, rw_q};
                pin_io_oe  = 8'hFF;
            end
            S_ADDR_LO: begin
                pin_out    = addr_q[7:0];
                pin_io_out = {7'b0, rw_q};
                pin_io_oe  = 8'hFF;
            end
            S_DATA: begin
                pin_out = addr_q[7:0];
                if (!rw_q) begin
                    pin_io_out = wdata_q;
                    pin_io_oe  = 8'hFF;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
